debug_settings_ctl: RTL and testbench



---
 rtl/debug_settings_ctl.sv | 166 ++++++++++++++++
 tb/tb_debug_settings_ctl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debug_settings_ctl.sv
// Debug mux settings controller: CPU bus loads a shadow copy of the
// channel words, and a commit transfers all of them to the live settings
// in one edge, either right away or at a programmed system time.

package settings;
  localparam int NUM_CH = 4;

  // Each channel word is {type[63:56], value[55:0]}.
  typedef struct packed {
    logic [NUM_CH-1:0][63:0] value;
  } debug_settings_t;
endpackage

// state | meaning
// ------+------------------------------------------------------------
// IDLE  | shadow/target writable, waiting for a commit
// ARMED | timed commit pending, comparing SYS_TIME[55:8] to target
// APPLY | single cycle, shadow copied to live settings on exit edge
module debug_settings_ctl #(
  parameter int NUM_CH    = settings::NUM_CH,
  parameter int BUS_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      BUS_WE,
  input  logic [4:0]                BUS_ADDR,
  input  logic [BUS_WIDTH-1:0]      BUS_DATA,
  input  logic [55:0]               SYS_TIME,
  output settings::debug_settings_t DEBUG_SETTINGS,
  output logic                      BUSY,
  output logic                      COMMIT_DONE,
  output logic                      ERR_LATE,
  output logic                      ERR_WRITE_DROP
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     wr_q;
  logic [4:0]               addr_q;
  logic [BUS_WIDTH-1:0]     data_q;
  logic [55:8]              sys_time_q;
  logic [55:8]              target_q;
  logic [NUM_CH-1:0][63:0]  shadow_q;

  logic shadow_wr, target_wr, ctl_wr;
  logic ctl_commit, ctl_timed, ctl_clr, ctl_cancel;
  logic do_apply, set_late, set_drop;

  // Only 256-tick granularity matters for activation.
  logic unused_time_bits;
  assign unused_time_bits = ^SYS_TIME[7:0];

  // Bus write and system time are registered so decode and time compare
  // both see the same sampled cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sys_time_q <= '0;
    end else begin
      wr_q       <= BUS_WE;
      addr_q     <= BUS_ADDR;
      data_q     <= BUS_DATA;
      sys_time_q <= SYS_TIME[55:8];
    end
  end

  assign shadow_wr  = wr_q && (addr_q < 5'd16);
  assign target_wr  = wr_q && (addr_q >= 5'd16) && (addr_q <= 5'd19);
  assign ctl_wr     = wr_q && (addr_q == 5'd20);
  assign ctl_commit = ctl_wr && data_q[0];
  assign ctl_timed  = data_q[1];
  assign ctl_clr    = ctl_wr && data_q[2];
  assign ctl_cancel = ctl_wr && data_q[3];

  assign BUSY = (state_q != IDLE);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle action strobes.
  always_comb begin
    state_d  = state_q;
    do_apply = 1'b0;
    set_late = 1'b0;
    set_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctl_commit) begin
          if (!ctl_timed) begin
            state_d = APPLY;
          end else if (target_q <= sys_time_q) begin
            state_d  = APPLY;
            set_late = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (shadow_wr || target_wr || ctl_commit) set_drop = 1'b1;
        // Cancel beats a simultaneous time match.
        if (ctl_cancel)                    state_d = IDLE;
        else if (sys_time_q == target_q)   state_d = APPLY;
      end
      APPLY: begin
        if (shadow_wr || target_wr) set_drop = 1'b1;
        do_apply = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow and target registers, writable only while idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_q <= '0;
      target_q <= '0;
    end else if (state_q == IDLE) begin
      if (shadow_wr) begin
        shadow_q[addr_q[3:2]][int'(addr_q[1:0])*BUS_WIDTH +: BUS_WIDTH] <= data_q;
      end
      if (target_wr) begin
        case (addr_q[1:0])
          2'd0:    target_q[15:8]  <= data_q[15:8];
          2'd1:    target_q[31:16] <= data_q;
          2'd2:    target_q[47:32] <= data_q;
          default: target_q[55:48] <= data_q[7:0];
        endcase
      end
    end
  end

  // Live settings update as a whole, with the done pulse in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DEBUG_SETTINGS <= '0;
      COMMIT_DONE    <= 1'b0;
    end else begin
      COMMIT_DONE <= do_apply;
      if (do_apply) DEBUG_SETTINGS.value <= shadow_q;
    end
  end

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_LATE       <= 1'b0;
      ERR_WRITE_DROP <= 1'b0;
    end else begin
      ERR_LATE       <= set_late | (ERR_LATE & ~ctl_clr);
      ERR_WRITE_DROP <= set_drop | (ERR_WRITE_DROP & ~ctl_clr);
    end
  end

endmodule

// File: tb/tb_debug_settings_ctl.sv
// Directed bench for debug_settings_ctl: immediate, timed, late, dropped,
// cancelled and reset-aborted commits with hand-computed expectations.
module tb_debug_settings_ctl;

  logic                      CLK = 1'b0;
  logic                      RST_N = 1'b0;
  logic                      BUS_WE = 1'b0;
  logic [4:0]                BUS_ADDR = '0;
  logic [15:0]               BUS_DATA = '0;
  logic [55:0]               SYS_TIME = '0;
  settings::debug_settings_t DEBUG_SETTINGS;
  logic                      BUSY, COMMIT_DONE, ERR_LATE, ERR_WRITE_DROP;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] CH0_A = 64'h0100_0000_0000_0001;
  localparam logic [63:0] CH0_B = 64'h0100_0000_2222_0001;
  localparam logic [63:0] CH1_A = 64'h0000_0000_0000_00AA;

  debug_settings_ctl dut (
    .CLK(CLK), .RST_N(RST_N), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_DATA(BUS_DATA), .SYS_TIME(SYS_TIME), .DEBUG_SETTINGS(DEBUG_SETTINGS),
    .BUSY(BUSY), .COMMIT_DONE(COMMIT_DONE), .ERR_LATE(ERR_LATE),
    .ERR_WRITE_DROP(ERR_WRITE_DROP)
  );

  always #5 CLK = ~CLK;

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    BUS_WE = 1'b1; BUS_ADDR = a; BUS_DATA = d;
    @(posedge CLK);
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (DEBUG_SETTINGS !== '0) begin errors++; $display("FAIL reset_settings got=%h exp=0", DEBUG_SETTINGS); end
    checks++; if ({BUSY, COMMIT_DONE, ERR_LATE, ERR_WRITE_DROP} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {BUSY, COMMIT_DONE, ERR_LATE, ERR_WRITE_DROP}); end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_immediate();
    bus_write(5'd0, 16'h0001);
    bus_write(5'd3, 16'h0100);
    bus_write(5'd20, 16'h0001);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL imm_busy_n got=%b exp=0", BUSY); end
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL imm_busy_n1 got=%b exp=1", BUSY); end
    checks++; if (DEBUG_SETTINGS.value[0] !== 64'h0) begin errors++; $display("FAIL imm_early got=%h exp=0", DEBUG_SETTINGS.value[0]); end
    checks++; if (COMMIT_DONE !== 1'b0) begin errors++; $display("FAIL imm_done_n1 got=%b exp=0", COMMIT_DONE); end
    step();
    checks++; if (DEBUG_SETTINGS.value[0] !== CH0_A) begin errors++; $display("FAIL imm_ch0 got=%h exp=%h", DEBUG_SETTINGS.value[0], CH0_A); end
    checks++; if (COMMIT_DONE !== 1'b1) begin errors++; $display("FAIL imm_done got=%b exp=1", COMMIT_DONE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL imm_busy_n2 got=%b exp=0", BUSY); end
    step();
    checks++; if (COMMIT_DONE !== 1'b0) begin errors++; $display("FAIL imm_done_width got=%b exp=0", COMMIT_DONE); end
    checks++; if (DEBUG_SETTINGS.value[0] !== CH0_A) begin errors++; $display("FAIL imm_hold got=%h exp=%h", DEBUG_SETTINGS.value[0], CH0_A); end
  endtask

  task automatic test_timed();
    SYS_TIME = 56'h1000;
    bus_write(5'd1, 16'h2222);
    bus_write(5'd16, 16'h1400);
    bus_write(5'd20, 16'h0003);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL timed_busy[%0d] got=%b exp=1", i, BUSY); end
      checks++; if (DEBUG_SETTINGS.value[0] !== CH0_A) begin errors++; $display("FAIL timed_wait[%0d] got=%h exp=%h", i, DEBUG_SETTINGS.value[0], CH0_A); end
      step();
    end
    SYS_TIME = 56'h1400;
    step();
    checks++; if (DEBUG_SETTINGS.value[0] !== CH0_A) begin errors++; $display("FAIL timed_m got=%h exp=%h", DEBUG_SETTINGS.value[0], CH0_A); end
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL timed_apply_busy got=%b exp=1", BUSY); end
    checks++; if (DEBUG_SETTINGS.value[0] !== CH0_A) begin errors++; $display("FAIL timed_m1 got=%h exp=%h", DEBUG_SETTINGS.value[0], CH0_A); end
    step();
    checks++; if (DEBUG_SETTINGS.value[0] !== CH0_B) begin errors++; $display("FAIL timed_ch0 got=%h exp=%h", DEBUG_SETTINGS.value[0], CH0_B); end
    checks++; if (COMMIT_DONE !== 1'b1) begin errors++; $display("FAIL timed_done got=%b exp=1", COMMIT_DONE); end
    checks++; if (ERR_LATE !== 1'b0) begin errors++; $display("FAIL timed_late got=%b exp=0", ERR_LATE); end
  endtask

  task automatic test_late();
    SYS_TIME = 56'h5000;
    bus_write(5'd4, 16'h00AA);
    bus_write(5'd16, 16'h4000);
    bus_write(5'd20, 16'h0003);
    checks++; if (ERR_LATE !== 1'b0) begin errors++; $display("FAIL late_n got=%b exp=0", ERR_LATE); end
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL late_busy got=%b exp=1", BUSY); end
    checks++; if (ERR_LATE !== 1'b1) begin errors++; $display("FAIL late_set got=%b exp=1", ERR_LATE); end
    step();
    checks++; if (COMMIT_DONE !== 1'b1) begin errors++; $display("FAIL late_done got=%b exp=1", COMMIT_DONE); end
    checks++; if (DEBUG_SETTINGS.value[1] !== CH1_A) begin errors++; $display("FAIL late_ch1 got=%h exp=%h", DEBUG_SETTINGS.value[1], CH1_A); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ERR_LATE !== 1'b1) begin errors++; $display("FAIL late_sticky[%0d] got=%b exp=1", i, ERR_LATE); end
    end
    bus_write(5'd20, 16'h0004);
    checks++; if (ERR_LATE !== 1'b1) begin errors++; $display("FAIL late_clr_k got=%b exp=1", ERR_LATE); end
    step();
    checks++; if (ERR_LATE !== 1'b0) begin errors++; $display("FAIL late_clr got=%b exp=0", ERR_LATE); end
  endtask

  task automatic test_drop_cancel();
    bus_write(5'd16, 16'h6000);
    bus_write(5'd20, 16'h0003);
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL drop_armed got=%b exp=1", BUSY); end
    bus_write(5'd5, 16'hFFFF);
    checks++; if (ERR_WRITE_DROP !== 1'b0) begin errors++; $display("FAIL drop_early got=%b exp=0", ERR_WRITE_DROP); end
    step();
    checks++; if (ERR_WRITE_DROP !== 1'b1) begin errors++; $display("FAIL drop_set got=%b exp=1", ERR_WRITE_DROP); end
    bus_write(5'd20, 16'h0008);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL cancel_k got=%b exp=1", BUSY); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({BUSY, COMMIT_DONE} !== 2'b00) begin errors++; $display("FAIL cancel_idle[%0d] got=%b exp=00", i, {BUSY, COMMIT_DONE}); end
    end
    checks++; if (DEBUG_SETTINGS.value[1] !== CH1_A) begin errors++; $display("FAIL cancel_hold got=%h exp=%h", DEBUG_SETTINGS.value[1], CH1_A); end
    bus_write(5'd20, 16'h0001);
    step(); step();
    checks++; if (COMMIT_DONE !== 1'b1) begin errors++; $display("FAIL drop_recommit got=%b exp=1", COMMIT_DONE); end
    checks++; if (DEBUG_SETTINGS.value[1] !== CH1_A) begin errors++; $display("FAIL drop_shadow got=%h exp=%h", DEBUG_SETTINGS.value[1], CH1_A); end
    checks++; if (ERR_WRITE_DROP !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", ERR_WRITE_DROP); end
    bus_write(5'd20, 16'h0004);
    step();
    checks++; if (ERR_WRITE_DROP !== 1'b0) begin errors++; $display("FAIL drop_clr got=%b exp=0", ERR_WRITE_DROP); end
  endtask

  task automatic test_cancel_match();
    bus_write(5'd8, 16'h0033);
    SYS_TIME = 56'h6000;
    bus_write(5'd16, 16'h7000);
    bus_write(5'd20, 16'h0003);
    step();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL cm_armed got=%b exp=1", BUSY); end
    SYS_TIME = 56'h7000;
    bus_write(5'd20, 16'h0008);
    step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL cm_idle got=%b exp=0", BUSY); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (COMMIT_DONE !== 1'b0) begin errors++; $display("FAIL cm_done[%0d] got=%b exp=0", i, COMMIT_DONE); end
    end
    checks++; if (DEBUG_SETTINGS.value[2] !== 64'h0) begin errors++; $display("FAIL cm_ch2 got=%h exp=0", DEBUG_SETTINGS.value[2]); end
    bus_write(5'd21, 16'h0001);
    step(); step();
    checks++; if ({BUSY, COMMIT_DONE} !== 2'b00) begin errors++; $display("FAIL ignored_addr got=%b exp=00", {BUSY, COMMIT_DONE}); end
  endtask

  task automatic test_reset_armed();
    bus_write(5'd12, 16'h1234);
    SYS_TIME = 56'h8000;
    bus_write(5'd16, 16'h9000);
    bus_write(5'd20, 16'h0003);
    step();
    bus_write(5'd2, 16'h5555);
    step();
    checks++; if ({BUSY, ERR_WRITE_DROP} !== 2'b11) begin errors++; $display("FAIL ra_pre got=%b exp=11", {BUSY, ERR_WRITE_DROP}); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (DEBUG_SETTINGS !== '0) begin errors++; $display("FAIL ra_settings got=%h exp=0", DEBUG_SETTINGS); end
    checks++; if ({BUSY, COMMIT_DONE, ERR_LATE, ERR_WRITE_DROP} !== 4'b0000) begin errors++; $display("FAIL ra_flags got=%b exp=0000", {BUSY, COMMIT_DONE, ERR_LATE, ERR_WRITE_DROP}); end
    step();
    RST_N = 1'b1;
    SYS_TIME = 56'h9000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({BUSY, COMMIT_DONE} !== 2'b00) begin errors++; $display("FAIL ra_idle[%0d] got=%b exp=00", i, {BUSY, COMMIT_DONE}); end
      checks++; if (DEBUG_SETTINGS !== '0) begin errors++; $display("FAIL ra_noapply[%0d] got=%h exp=0", i, DEBUG_SETTINGS); end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_timed();
    test_late();
    test_drop_cancel();
    test_cancel_match();
    test_reset_armed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
